// File: rtl/cpu301_pkg.sv
// Shared definitions for the 301 16-bit RISC datapath and control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu301_pkg;

  // Default datapath geometry
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int OFF_W  = 8;
  localparam int FCNT_W = 16;

  // PC value taken on reset
  localparam logic [15:0] RESET_PC = 16'h0000;

  // cu state encodings, shared so debug logic can decode the cu state bus
  typedef enum logic [2:0] {
    CU_RESET  = 3'd0,
    CU_FETCH  = 3'd1,
    CU_DECODE = 3'd2,
    CU_EXEC   = 3'd3,
    CU_MEM    = 3'd4,
    CU_WB     = 3'd5,
    CU_HALT   = 3'd6
  } cu_state_t;

  // Control word the cu hands to the PC/IR stage
  typedef struct packed {
    logic pc_ld;
    logic pc_inc;
    logic pc_sel;
    logic ir_ld;
    logic adr_sel;
  } pc_ctl_t;

endpackage

// File: rtl/pc_ir_unit_bp_compare.sv
// Single-address breakpoint comparator, reusable by the debug block.
// Latency: combinational, 0 cycles.
// Backpressure: none; match is advisory only.
module bp_compare #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
  input  logic              strobe,
  output logic              match
);

  // Match only on a fetch strobe so data accesses never trip the breakpoint
  assign match = strobe & bp_en & (pc == bp_addr);

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR / memory-address stage: fetch capture, PC sequencing, fetch counter, breakpoint.
// Latency: registers update on the rising edge; se_IR and mem_addr are combinational.
// Backpressure: none; never stalls cu, bp_hit is advisory.
import cpu301_pkg::*;

module pc_ir_unit #(
  parameter int                         DATA_W   = cpu301_pkg::DATA_W,
  parameter int                         ADDR_W   = cpu301_pkg::ADDR_W,
  parameter int                         OFF_W    = cpu301_pkg::OFF_W,
  parameter logic [cpu301_pkg::ADDR_W-1:0] RESET_PC = cpu301_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_ld,
  input  logic              pc_inc,
  input  logic              pc_sel,
  input  logic              ir_ld,
  input  logic              adr_sel,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] reg_r,
  input  logic [DATA_W-1:0] reg_s,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] se_IR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       fetch_cnt,
  output logic              bp_hit
);

  pc_ctl_t           ctl;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] pc_branch;
  logic [ADDR_W-1:0] pc_next;
  logic              bp_match;

  assign ctl = '{pc_ld: pc_ld, pc_inc: pc_inc, pc_sel: pc_sel,
                 ir_ld: ir_ld, adr_sel: adr_sel};

  // Branch offset lives in the low IR bits; sign-extend for cu and for the PC adder
  assign se_IR   = {{(DATA_W-OFF_W){IR[OFF_W-1]}}, IR[OFF_W-1:0]};
  assign off_ext = {{(ADDR_W-OFF_W){IR[OFF_W-1]}}, IR[OFF_W-1:0]};

  // PC already points past the branch, so the offset is applied to PC as-is; wraps mod 2^ADDR_W
  assign pc_branch = PC + off_ext;

  // Data accesses use the R-port register; everything else addresses by PC
  assign mem_addr = ctl.adr_sel ? reg_r[ADDR_W-1:0] : PC;

  // PC source select: a load beats an increment even though cu never asserts both
  always_comb begin
    pc_next = PC;
    if (ctl.pc_ld) begin
      pc_next = ctl.pc_sel ? reg_s[ADDR_W-1:0] : pc_branch;
    end else if (ctl.pc_inc) begin
      pc_next = PC + ADDR_W'(1);
    end
  end

  // Program counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC <= RESET_PC;
    end else begin
      PC <= pc_next;
    end
  end

  // Instruction register: captures the word addressed by the pre-edge PC on a fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IR <= '0;
    end else if (ctl.ir_ld) begin
      IR <= mem_dout;
    end
  end

  // Fetch counter, free-running wrap at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
    end else if (ctl.ir_ld) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  bp_compare #(
    .ADDR_W (ADDR_W)
  ) u_bp_compare (
    .pc      (PC),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .strobe  (ctl.ir_ld),
    .match   (bp_match)
  );

  // Sticky breakpoint flag: only reset clears it, dropping bp_en does not
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_hit <= 1'b0;
    end else if (bp_match) begin
      bp_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed cases plus randomized control words.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_ld, pc_inc, pc_sel, ir_ld, adr_sel;
  logic [15:0] mem_dout, reg_r, reg_s;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic [15:0] IR, PC, se_IR, mem_addr, fetch_cnt;
  logic        bp_hit;

  logic [15:0] m_pc, m_ir, m_cnt;
  logic        m_bp;
  logic        chk_en;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pc_ir_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc_ld     (pc_ld),
    .pc_inc    (pc_inc),
    .pc_sel    (pc_sel),
    .ir_ld     (ir_ld),
    .adr_sel   (adr_sel),
    .mem_dout  (mem_dout),
    .reg_r     (reg_r),
    .reg_s     (reg_s),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .IR        (IR),
    .PC        (PC),
    .se_IR     (se_IR),
    .mem_addr  (mem_addr),
    .fetch_cnt (fetch_cnt),
    .bp_hit    (bp_hit)
  );

  // Signed value of the low 8 bits of an instruction word
  function automatic int offset_of(input logic [15:0] ir);
    int v;
    v = int'(ir[7:0]);
    if (v > 127) v = v - 256;
    return v;
  endfunction

  function automatic logic [15:0] model_se(input logic [15:0] ir);
    return 16'((offset_of(ir) + 65536) % 65536);
  endfunction

  function automatic logic [15:0] model_next_pc(input logic [15:0] pc, input logic [15:0] ir,
                                                input logic [15:0] rs, input logic ld,
                                                input logic sel, input logic inc);
    if (ld && sel) return rs;
    if (ld)        return 16'((int'(pc) + offset_of(ir) + 65536) % 65536);
    if (inc)       return 16'((int'(pc) + 1) % 65536);
    return pc;
  endfunction

  // Reference model state, advanced from the rules on each edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc  <= 16'h0000;
      m_ir  <= 16'h0000;
      m_cnt <= 16'h0000;
      m_bp  <= 1'b0;
    end else begin
      m_pc <= model_next_pc(m_pc, m_ir, reg_s, pc_ld, pc_sel, pc_inc);
      if (ir_ld) begin
        m_ir  <= mem_dout;
        m_cnt <= 16'((int'(m_cnt) + 1) % 65536);
        if (bp_en && (m_pc == bp_addr)) m_bp <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_pc",        PC,        m_pc);
        chk("cyc_ir",        IR,        m_ir);
        chk("cyc_se_ir",     se_IR,     model_se(m_ir));
        chk("cyc_mem_addr",  mem_addr,  adr_sel ? reg_r : m_pc);
        chk("cyc_fetch_cnt", fetch_cnt, m_cnt);
        chk("cyc_bp_hit",    {15'd0, bp_hit}, {15'd0, m_bp});
      end
    end
  endtask

  task automatic ctl(input logic ld, input logic sel, input logic inc,
                     input logic irl, input logic asel);
    pc_ld   = ld;
    pc_sel  = sel;
    pc_inc  = inc;
    ir_ld   = irl;
    adr_sel = asel;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    reset    = 1'b1;
    chk_en   = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_dout = 16'h7E05;
    reg_r    = 16'h0000;
    reg_s    = 16'h0000;
    bp_en    = 1'b0;
    bp_addr  = 16'h0000;
    fork
      compare_loop();
    join_none

    // Reset state
    #1;
    chk("rst_pc",        PC,        16'h0000);
    chk("rst_ir",        IR,        16'h0000);
    chk("rst_fetch_cnt", fetch_cnt, 16'h0000);
    chk("rst_bp_hit",    {15'd0, bp_hit}, 16'h0000);
    chk("rst_mem_addr",  mem_addr,  16'h0000);
    cyc();
    cyc();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Fetch at PC 0010
    reg_s = 16'h0010;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("ld_pc_0010", PC, 16'h0010);
    mem_dout = 16'h7C03;
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("fetch_ir",  IR,        16'h7C03);
    chk("fetch_pc",  PC,        16'h0011);
    chk("fetch_cnt", fetch_cnt, 16'h0001);

    // Backward branch with IR 7CFE from PC 0011
    mem_dout = 16'h7CFE;
    cyc();
    reg_s = 16'h0011;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("se_ir_fffe", se_IR, 16'hFFFE);
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("br_back_pc",    PC,   16'h000F);
    chk("model_br_back", m_pc, 16'h000F);

    // Forward branch wrapping from FFF0 with IR 7C7F
    mem_dout = 16'h7C7F;
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    reg_s = 16'hFFF0;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("br_wrap_pc",    PC,    16'h006F);
    chk("se_ir_007f",    se_IR, 16'h007F);
    chk("model_br_wrap", m_pc,  16'h006F);

    // Register jump, and load winning over increment
    reg_s = 16'h1234;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("jmp_pc", PC, 16'h1234);
    ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("ld_beats_inc", PC, 16'h1234);

    // Data address from R port, then LDI
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reg_r = 16'hABCD;
    #1;
    chk("adr_reg_r", mem_addr, 16'hABCD);
    cyc();
    chk("adr_pc_hold", PC, 16'h1234);
    reg_s = 16'h0020;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_dout = 16'h5555;
    #1;
    chk("ldi_mem_addr", mem_addr, 16'h0020);
    cyc();
    chk("ldi_pc", PC, 16'h0021);
    chk("ldi_ir_hold", IR, 16'h7C7F);

    // Breakpoint at 0005, sticky after bp_en drops
    bp_addr = 16'h0005;
    bp_en   = 1'b1;
    reg_s   = 16'h0005;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("bp_before", {15'd0, bp_hit}, 16'h0000);
    mem_dout = 16'h1111;
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("bp_hit_set",   {15'd0, bp_hit}, 16'h0001);
    chk("bp_fetch_pc",  PC,   16'h0006);
    chk("model_bp_set", {15'd0, m_bp}, 16'h0001);
    bp_en = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("bp_sticky", {15'd0, bp_hit}, 16'h0001);

    // Fetch wrap FFFF -> 0000
    reg_s = 16'hFFFF;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    mem_dout = 16'h2222;
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("wrap_pc",        PC,        16'h0000);
    chk("wrap_fetch_cnt", fetch_cnt, 16'h0005);
    chk("wrap_bp_still",  {15'd0, bp_hit}, 16'h0001);

    // Reset arriving mid-cycle with a jump pending
    reg_s = 16'h4321;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_pc",  PC,        16'h0000);
    chk("midrst_bp",  {15'd0, bp_hit}, 16'h0000);
    chk("midrst_cnt", fetch_cnt, 16'h0000);
    chk("midrst_ir",  IR,        16'h0000);
    cyc();
    chk("midrst_edge_pc", PC, 16'h0000);
    reset = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();

    // Randomized control words checked by the per-cycle compare
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        3:       ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        4:       ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        5:       ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        6:       ctl(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
        default: ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
      endcase
      mem_dout = 16'($urandom);
      reg_r    = 16'($urandom);
      reg_s    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      bp_en    = 1'($urandom);
      bp_addr  = 16'($urandom_range(0, 15));
      reset    = (i == 200);
      cyc();
    end
    reset = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
